// File: rtl/updown_sequencer.sv
// Sweep sequencer that drives an external up/down counter: up to a latched limit, dwell,
// back down to zero. Define SEQ_LOOP_EN to repeat sweeps (via HOLD_BOT) until stop or reset.
module updown_sequencer #(
  parameter int unsigned WIDTH      = 18,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] count,
  output logic             run,
  output logic             dir_up,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state,
  output logic [7:0]       pass_cnt
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StUp      = 3'd1,
    StHoldTop = 3'd2,
    StDown    = 3'd3,
    StHoldBot = 3'd4
  } state_e;

  localparam logic [7:0] HoldLast = (HOLD_TICKS == 0) ? 8'd0 : 8'(HOLD_TICKS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lim_q, lim_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic [7:0]       pass_cnt_q, pass_cnt_d;
  logic             done_q, done_d;
  logic             busy_q, dir_up_q;
  logic             hold_exit;

  // A zero-length dwell leaves the hold state unconditionally after one cycle.
  assign hold_exit = (HOLD_TICKS == 0) || (tick && (hold_cnt_q == HoldLast));

  always_comb begin
    state_d    = state_q;
    lim_d      = lim_q;
    hold_cnt_d = hold_cnt_q;
    pass_cnt_d = pass_cnt_q;
    done_d     = 1'b0;
    case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d = StUp;
          lim_d   = limit;
        end
      end
      StUp: begin
        if (count >= lim_q) begin
          state_d    = StHoldTop;
          hold_cnt_d = 8'd0;
        end
      end
      StHoldTop: begin
        if (tick) hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_exit) state_d = StDown;
      end
      StDown: begin
        if (count == '0) begin
          done_d     = 1'b1;
          pass_cnt_d = pass_cnt_q + 8'd1;
          hold_cnt_d = 8'd0;
`ifdef SEQ_LOOP_EN
          state_d    = StHoldBot;
`else
          state_d    = StIdle;
`endif
        end
      end
      StHoldBot: begin
        if (tick) hold_cnt_d = hold_cnt_q + 8'd1;
        if (hold_exit) state_d = StUp;
      end
      default: state_d = StIdle;
    endcase
    // Abort overrides everything, including a pass completing in the same cycle.
    if (stop && (state_q != StIdle)) begin
      state_d    = StIdle;
      done_d     = 1'b0;
      pass_cnt_d = pass_cnt_q;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= StIdle;
      lim_q      <= '0;
      hold_cnt_q <= 8'd0;
      pass_cnt_q <= 8'd0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      dir_up_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      lim_q      <= lim_d;
      hold_cnt_q <= hold_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      done_q     <= done_d;
      busy_q     <= (state_d != StIdle);
      dir_up_q   <= !((state_d == StHoldTop) || (state_d == StDown));
    end
  end

  // Enable drops at the end points themselves, so the counter never overshoots.
  assign run      = ((state_q == StUp) && (count < lim_q)) ||
                    ((state_q == StDown) && (count != '0));
  assign dir_up   = dir_up_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign state    = state_q;
  assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_updown_sequencer.sv
// Directed bench for updown_sequencer with a tick-driven counter model and a done scoreboard.
// Covers both builds; loop-only scenarios are selected with SEQ_LOOP_EN.
module tb_updown_sequencer;

  localparam int unsigned W = 18;
`ifdef SEQ_LOOP_EN
  localparam int unsigned MainHold = 1;
`else
  localparam int unsigned MainHold = 2;
`endif

  logic CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  logic         reset;
  logic         tick;
  logic [1:0]   div;
  logic         m_start, m_stop, m_run, m_dir_up, m_busy, m_done;
  logic [W-1:0] m_limit, m_count;
  logic [2:0]   m_state;
  logic [7:0]   m_pass_cnt;
  logic         z_start, z_stop, z_run, z_dir_up, z_busy, z_done;
  logic [W-1:0] z_limit, z_count;
  logic [2:0]   z_state;
  logic [7:0]   z_pass_cnt;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int m_done_seen = 0;
  int exp_q[$];
  bit have_exp;

  updown_sequencer #(.WIDTH(W), .HOLD_TICKS(MainHold)) u_main (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick), .start(m_start), .stop(m_stop),
    .limit(m_limit), .count(m_count), .run(m_run), .dir_up(m_dir_up), .busy(m_busy),
    .done(m_done), .state(m_state), .pass_cnt(m_pass_cnt)
  );

  updown_sequencer #(.WIDTH(W), .HOLD_TICKS(0)) u_h0 (
    .CLOCK_50(CLOCK_50), .reset(reset), .tick(tick), .start(z_start), .stop(z_stop),
    .limit(z_limit), .count(z_count), .run(z_run), .dir_up(z_dir_up), .busy(z_busy),
    .done(z_done), .state(z_state), .pass_cnt(z_pass_cnt)
  );

  // Clock divider and external up/down counters, stepping on tick while enabled.
  assign tick = (div == 2'd3);
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div     <= 2'd0;
      m_count <= '0;
      z_count <= '0;
    end else begin
      div <= div + 2'd1;
      if (m_run && tick) m_count <= m_dir_up ? m_count + 1'b1 : m_count - 1'b1;
      if (z_run && tick) z_count <= z_dir_up ? z_count + 1'b1 : z_count - 1'b1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse of u_main must match a queued expected pass count.
  always @(negedge CLOCK_50) begin
    if (m_done) begin
      m_done_seen++;
      have_exp = (exp_q.size() != 0);
      check("done_expected", int'(have_exp), 1);
      if (have_exp) check("done_pass_cnt", int'(m_pass_cnt), exp_q.pop_front());
    end
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_start = 1'b0; m_stop = 1'b0; z_start = 1'b0; z_stop = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_m(input int st, input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (int'(m_state) == st) begin ok = 1'b1; break; end
      step();
    end
    check(tag, int'(ok), 1);
  endtask

  task automatic wait_z(input int st, input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (int'(z_state) == st) begin ok = 1'b1; break; end
      step();
    end
    check(tag, int'(ok), 1);
  endtask

`ifdef SEQ_LOOP_EN
  function automatic int nxt(input int s);
    return (s == 4) ? 1 : s + 1;
  endfunction
`endif

  initial begin
    int  mx;
    bit  ok;
    int  dones;
    int  prev;
    int  seen0;
    bit  drop;

    reset = 1'b1;
    m_start = 1'b0; m_stop = 1'b0; m_limit = '0;
    z_start = 1'b0; z_stop = 1'b0; z_limit = '0;
    step(); step();

    // Reset values, with start pending to show reset has priority
    m_start = 1'b1; m_limit = 18'd5;
    step();
    check("rst_state", int'(m_state), 0);
    check("rst_busy", int'(m_busy), 0);
    check("rst_dir_up", int'(m_dir_up), 1);
    check("rst_done", int'(m_done), 0);
    check("rst_pass_cnt", int'(m_pass_cnt), 0);
    check("rst_run", int'(m_run), 0);
    check("rst_z_state", int'(z_state), 0);
    m_start = 1'b0;
    reset = 1'b0;
    step();

    // start and stop together in IDLE
    m_limit = 18'd4; m_start = 1'b1; m_stop = 1'b1;
    step();
    m_start = 1'b0; m_stop = 1'b0;
    check("collide_state", int'(m_state), 0);
    check("collide_busy", int'(m_busy), 0);

    // limit = 0: UP for one cycle then HOLD_TOP, run never high
    m_limit = '0; m_start = 1'b1;
    step();
    m_start = 1'b0;
    check("lim0_up", int'(m_state), 1);
    check("lim0_run_up", int'(m_run), 0);
    check("lim0_busy", int'(m_busy), 1);
    step();
    check("lim0_hold", int'(m_state), 2);
    check("lim0_run_hold", int'(m_run), 0);
    check("lim0_dir_up", int'(m_dir_up), 0);
    m_stop = 1'b1;
    step();
    m_stop = 1'b0;
    check("lim0_stop", int'(m_state), 0);

`ifndef SEQ_LOOP_EN
    // Single pass to 3 and back
    do_reset();
    m_limit = 18'd3; m_start = 1'b1;
    exp_q.push_back(1);
    step();
    m_start = 1'b0;
    mx = 0; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (int'(m_count) > mx) mx = int'(m_count);
      if (m_done) begin ok = 1'b1; break; end
      step();
    end
    check("pass_done", int'(ok), 1);
    check("pass_state", int'(m_state), 0);
    check("pass_run", int'(m_run), 0);
    check("pass_busy", int'(m_busy), 0);
    check("pass_cnt", int'(m_pass_cnt), 1);
    check("pass_max_count", mx, 3);
    step(); step();
    check("pass_done_low", int'(m_done), 0);
    check("pass_done_once", m_done_seen, 1);
`else
    // Three looping passes with limit 2
    do_reset();
    m_limit = 18'd2; m_start = 1'b1;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    step();
    m_start = 1'b0;
    check("loop_first", int'(m_state), 1);
    prev = int'(m_state); dones = 0; drop = 1'b0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (!m_busy) drop = 1'b1;
      if (int'(m_state) != prev) begin
        check("loop_order", int'(m_state), nxt(prev));
        prev = int'(m_state);
      end
      if (m_done) dones++;
      if (dones == 3) break;
    end
    check("loop_dones", dones, 3);
    check("loop_pass_cnt", int'(m_pass_cnt), 3);
    check("loop_busy_held", int'(drop), 0);
    m_stop = 1'b1;
    step();
    m_stop = 1'b0;
    check("loop_stop", int'(m_state), 0);
`endif

    // Reset during HOLD_TOP, then a fresh start latches limit 7
    m_limit = 18'd8; m_start = 1'b1;
    step();
    m_start = 1'b0;
    wait_m(2, 800, "rst_mid_reach");
    reset = 1'b1;
    step();
    check("rst_mid_state", int'(m_state), 0);
    check("rst_mid_busy", int'(m_busy), 0);
    check("rst_mid_dir_up", int'(m_dir_up), 1);
    check("rst_mid_done", int'(m_done), 0);
    check("rst_mid_pass_cnt", int'(m_pass_cnt), 0);
    check("rst_mid_run", int'(m_run), 0);
    reset = 1'b0;
    m_limit = 18'd7; m_start = 1'b1;
    step();
    m_start = 1'b0;
    m_limit = 18'd2;
    wait_m(2, 800, "lim7_reach");
    check("lim7_count", int'(m_count), 7);
    m_stop = 1'b1;
    step();
    m_stop = 1'b0;

    // stop in DOWN at count 5, on a non-tick cycle
    do_reset();
    seen0 = m_done_seen;
    m_limit = 18'd8; m_start = 1'b1;
    step();
    m_start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (m_state == 3'd3 && m_count == 18'd5 && !tick) begin ok = 1'b1; break; end
      step();
    end
    check("stop_reach", int'(ok), 1);
    m_stop = 1'b1;
    step();
    m_stop = 1'b0;
    check("stop_state", int'(m_state), 0);
    check("stop_run", int'(m_run), 0);
    check("stop_count", int'(m_count), 5);
    for (int i = 0; i < 8; i++) step();
    check("stop_frozen", int'(m_count), 5);
    check("stop_no_done", m_done_seen, seen0);

    // HOLD_TICKS = 0: each hold lasts one cycle
    do_reset();
    z_limit = 18'd1; z_start = 1'b1;
    step();
    z_start = 1'b0;
    wait_z(2, 100, "h0_top_reach");
    step();
    check("h0_top_len", int'(z_state), 3);
`ifndef SEQ_LOOP_EN
    wait_z(0, 100, "h0_idle_reach");
    check("h0_pass_cnt", int'(z_pass_cnt), 1);
`else
    wait_z(4, 100, "h0_bot_reach");
    step();
    check("h0_bot_len", int'(z_state), 1);
    z_stop = 1'b1;
    step();
    z_stop = 1'b0;

    // 256 looping passes wrap pass_cnt to zero
    do_reset();
    z_limit = 18'd1; z_start = 1'b1;
    step();
    z_start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8000; i++) begin
      step();
      if (z_done) begin
        dones++;
        if (dones == 255) check("wrap_255", int'(z_pass_cnt), 255);
        if (dones == 256) break;
      end
    end
    check("wrap_count", dones, 256);
    check("wrap_zero", int'(z_pass_cnt), 0);
    check("wrap_busy", int'(z_busy), 1);
    z_stop = 1'b1;
    step();
    z_stop = 1'b0;
`endif

    step(); step();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
